// File: rtl/flag_ctrl.sv
// flag_ctrl: arbitrates ALU flag writes against clear/save/restore of a small flag save stack.
// Optional registered branch-condition evaluator is enabled by defining FLAG_CTRL_COND_EN.
module flag_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid,
  input  logic       alu_cb_valid,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_b,
  input  logic       save_req,
  input  logic       restore_req,
  input  logic       clr_req,
  input  logic       flag_c,
  input  logic       flag_z,
  input  logic       flag_b,
  input  logic [2:0] cond_sel,
  output logic       flag_rst,
  output logic       flag_cb_valid,
  output logic       flag_c_in,
  output logic       flag_z_in,
  output logic       flag_b_in,
  output logic       alu_stall,
  output logic       save_ack,
  output logic       restore_ack,
  output logic       clr_ack,
  output logic       stk_full,
  output logic       stk_empty,
  output logic       stk_err,
  output logic       busy,
  output logic       cond_true
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, PUSH, POP} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    stack_mem [DEPTH];
  logic          any_req, alu_grant;

  assign any_req   = clr_req | restore_req | save_req;
  assign alu_grant = (state == IDLE) & alu_valid & ~any_req;
  assign alu_stall = alu_valid & ~alu_grant;
  assign stk_full  = (count == FULL_CNT);
  assign stk_empty = (count == '0);
  assign busy      = (state != IDLE);
  assign wr_ptr    = count[AW-1:0];
  assign rd_ptr    = wr_ptr - AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (state == IDLE) begin
      if (clr_req)          state_nxt = CLEAR;
      else if (restore_req) state_nxt = POP;
      else if (save_req)    state_nxt = PUSH;
    end
  end

  // Default is to hold the flag register; ops and granted ALU writes override it.
  always_comb begin
    flag_rst      = 1'b0;
    flag_cb_valid = 1'b0;
    flag_c_in     = flag_c;
    flag_z_in     = flag_z;
    flag_b_in     = flag_b;
    save_ack      = 1'b0;
    restore_ack   = 1'b0;
    clr_ack       = 1'b0;
    case (state)
      IDLE: begin
        if (alu_grant) begin
          flag_c_in     = alu_c;
          flag_z_in     = alu_z;
          flag_b_in     = alu_b;
          flag_cb_valid = alu_cb_valid;
        end
      end
      CLEAR: begin
        flag_rst = 1'b1;
        clr_ack  = 1'b1;
      end
      PUSH: save_ack = 1'b1;
      POP: begin
        restore_ack = 1'b1;
        if (!stk_empty) begin
          {flag_c_in, flag_z_in, flag_b_in} = stack_mem[rd_ptr];
          flag_cb_valid = 1'b1;
        end
      end
      default: ;
    endcase
    if (!rst_n) flag_rst = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      stk_err <= 1'b0;
    end else begin
      case (state)
        CLEAR: stk_err <= 1'b0;
        PUSH: begin
          if (stk_full) stk_err <= 1'b1;
          else          count   <= count + (AW+1)'(1);
        end
        POP: begin
          if (stk_empty) stk_err <= 1'b1;
          else           count   <= count - (AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (state == PUSH && !stk_full) stack_mem[wr_ptr] <= {flag_c, flag_z, flag_b};
  end

`ifdef FLAG_CTRL_COND_EN
  logic cond_nxt;

  always_comb begin
    cond_nxt = 1'b1;
    case (cond_sel)
      3'd0: cond_nxt = 1'b1;
      3'd1: cond_nxt = flag_z;
      3'd2: cond_nxt = ~flag_z;
      3'd3: cond_nxt = flag_c;
      3'd4: cond_nxt = ~flag_c;
      3'd5: cond_nxt = flag_b;
      3'd6: cond_nxt = ~flag_b;
      3'd7: cond_nxt = flag_c & ~flag_z;
      default: cond_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cond_true <= 1'b0;
    else        cond_true <= cond_nxt;
  end
`else
  logic unused_cond;
  assign unused_cond = ^cond_sel;
  assign cond_true   = 1'b0;
`endif

endmodule
